rv32v_element_sequencer: RTL and testbench

- Sits between vector decode and vector execute.
- Accepts one decoded vector instruction (vl, vstart, mask enable, v0 mask bits) and walks its element indices two per cycle, one per lane.
- For each group it produces lane element offsets, lane mask bits and per-lane write enables that execute consumes alongside the other decoded fields.
- Handles execute backpressure, flush, tail elements and vstart-resumed instructions.

---
 rtl/rv32v_element_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rv32v_element_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_element_sequencer.sv
// Vector element sequencer. Sits between vector decode and vector execute,
// latching one decoded instruction and walking its element indices two per
// cycle (lane 0 = idx, lane 1 = idx+1). Each group carries lane offsets, the
// v0 mask bits of the lanes and per-lane write enables. The sequencer also
// handles execute backpressure, flush, tail elements and vstart-resumed
// instructions.
module rv32v_element_sequencer #(
  parameter int VLMAX = 128,
  parameter int IDXW  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [31:0]       vl,
  input  logic [31:0]       vstart,
  input  logic              is_masked,
  input  logic [VLMAX-1:0]  v0_bits,
  input  logic              stall,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic [IDXW-1:0]   woffset0,
  output logic [IDXW-1:0]   woffset1,
  output logic              mask0,
  output logic              mask1,
  output logic [1:0]        wen,
  output logic              last,
  output logic              done,
  output logic              vstart_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Architectural state of the instruction in flight.
  state_t             state_q;
  logic [IDXW-1:0]    idx_q;
  logic [IDXW-1:0]    vl_q;
  logic [VLMAX-1:0]   v0_q;
  logic               masked_q;

  // Registered control outputs, updated together with the state.
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  // Start-time values: vl clamped to VLMAX with a full 32-bit compare, and
  // the empty test done against the clamped length with the full vstart so
  // that a huge vstart cannot alias onto a small index.
  logic               vl_over_d;
  logic [IDXW-1:0]    vl_clamp_d;
  logic               empty_d;

  // Group arithmetic is done one bit wider than the index so idx+1 and
  // idx+2 never wrap at VLMAX.
  logic [IDXW:0]      idx_ext;
  logic [IDXW:0]      vl_ext;
  logic [IDXW:0]      idx_p1;
  logic [IDXW:0]      idx_p2;
  logic               lane0_act;
  logic               lane1_act;
  logic               last_d;

  // v0 bits for the two lanes of the current group. Shifting instead of
  // indexing keeps lane 1 legal when idx+1 == VLMAX; such a lane is
  // inactive anyway, so the shifted-in zero is never consumed.
  logic [1:0]         v0_pair;

  // Write kill: a flush (or reset) cycle must not commit any element.
  logic               kill;

  assign vl_over_d  = (vl > 32'(VLMAX));
  assign vl_clamp_d = vl_over_d ? IDXW'(VLMAX) : vl[IDXW-1:0];
  assign empty_d    = (vstart >= {{(32-IDXW){1'b0}}, vl_clamp_d});

  assign idx_ext    = {1'b0, idx_q};
  assign vl_ext     = {1'b0, vl_q};
  assign idx_p1     = idx_ext + 1'b1;
  assign idx_p2     = idx_ext + 2'd2;
  assign lane0_act  = (idx_ext < vl_ext);
  assign lane1_act  = (idx_p1 < vl_ext);
  assign last_d     = (idx_p2 >= vl_ext);

  assign v0_pair    = 2'(v0_q >> idx_q);
  assign kill       = flush | RST;

  // Group outputs are derived from the held state, so a stall keeps them
  // stable for free; only wen is additionally cut by a flush/reset cycle.
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vstart_clr = done_q;
  assign woffset0   = idx_q;
  assign woffset1   = idx_p1[IDXW-1:0];
  assign mask0      = busy_q & lane0_act & v0_pair[0];
  assign mask1      = busy_q & lane1_act & v0_pair[1];
  assign wen[0]     = busy_q & lane0_act & (~masked_q | v0_pair[0]) & ~kill;
  assign wen[1]     = busy_q & lane1_act & (~masked_q | v0_pair[1]) & ~kill;
  assign last       = busy_q & last_d;

  // Sequencer FSM: reset, then flush, then the per-state transitions.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      vl_q     <= '0;
      v0_q     <= '0;
      masked_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (flush) begin
      // Abort wins over stall and start; no completion pulse is produced.
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            vl_q     <= vl_clamp_d;
            idx_q    <= vstart[IDXW-1:0];
            v0_q     <= v0_bits;
            masked_q <= is_masked;
            ready_q  <= 1'b0;
            if (empty_d) begin
              // Nothing to issue: complete straight away.
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (last_d) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_p2[IDXW-1:0];
            end
          end
        end
        S_FIN: begin
          // Single completion cycle; ready only returns afterwards so a new
          // start can never coincide with done.
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Bench for rv32v_element_sequencer: directed instructions with literal
// expectations, plus a queue-based reference that lists every output cycle
// an accepted instruction must produce and is checked on every falling edge.
module tb_rv32v_element_sequencer;
  localparam int VLMAX = 128;
  localparam int IDXW  = 8;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [31:0]       vl;
  logic [31:0]       vstart;
  logic              is_masked;
  logic [VLMAX-1:0]  v0_bits;
  logic              stall;
  logic              flush;
  logic              ready;
  logic              busy;
  logic [IDXW-1:0]   woffset0;
  logic [IDXW-1:0]   woffset1;
  logic              mask0;
  logic              mask1;
  logic [1:0]        wen;
  logic              last;
  logic              done;
  logic              vstart_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rv32v_element_sequencer #(.VLMAX(VLMAX), .IDXW(IDXW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .vl(vl), .vstart(vstart),
    .is_masked(is_masked), .v0_bits(v0_bits), .stall(stall), .flush(flush),
    .ready(ready), .busy(busy), .woffset0(woffset0), .woffset1(woffset1),
    .mask0(mask0), .mask1(mask1), .wen(wen), .last(last), .done(done),
    .vstart_clr(vstart_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One entry per output cycle of an accepted instruction.
  typedef struct {
    bit       fin;
    int       off0;
    bit       m0;
    bit       m1;
    bit [1:0] wen;
    bit       last;
  } exp_t;

  exp_t exp_q[$];
  bit   armed = 1'b0;

  // Expand an instruction into its list of groups followed by the FIN cycle.
  function automatic void push_instr();
    exp_t e;
    longint unsigned vlc;
    longint unsigned vs;
    bit a1;
    vlc = (vl > 32'd128) ? 128 : longint'(vl);
    vs  = longint'(vstart);
    if (vs < vlc) begin
      for (longint unsigned i = vs; i < vlc; i += 2) begin
        a1     = (i + 1 < vlc);
        e.fin  = 1'b0;
        e.off0 = int'(i);
        e.m0   = v0_bits[int'(i)];
        e.m1   = a1 ? v0_bits[int'(i) + 1] : 1'b0;
        e.wen  = {a1 && (!is_masked || e.m1), (!is_masked || e.m0)};
        e.last = (i + 2 >= vlc);
        exp_q.push_back(e);
      end
    end
    e.fin  = 1'b1;
    e.off0 = 0;
    e.m0   = 1'b0;
    e.m1   = 1'b0;
    e.wen  = 2'b00;
    e.last = 1'b0;
    exp_q.push_back(e);
  endfunction

  // Reference advance on each rising edge, using the inputs just sampled.
  always @(posedge CLK) begin
    if (RST) begin
      exp_q.delete();
      armed = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (start) push_instr();
    end else if (exp_q[0].fin || !stall) begin
      void'(exp_q.pop_front());
    end
  end

  // Compare the DUT against the reference head on every falling edge.
  always @(negedge CLK) begin
    if (armed) begin
      if (exp_q.size() == 0) begin
        chk("idle_ready", ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_vclr", vstart_clr, 0);
        chk("idle_wen", wen, 0);
        chk("idle_last", last, 0);
      end else if (exp_q[0].fin) begin
        chk("fin_ready", ready, 0);
        chk("fin_busy", busy, 0);
        chk("fin_done", done, 1);
        chk("fin_vclr", vstart_clr, 1);
        chk("fin_wen", wen, 0);
      end else begin
        chk("run_ready", ready, 0);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_off0", woffset0, exp_q[0].off0);
        chk("run_off1", woffset1, exp_q[0].off0 + 1);
        chk("run_mask0", mask0, exp_q[0].m0);
        chk("run_mask1", mask1, exp_q[0].m1);
        chk("run_wen", wen, (flush || RST) ? 2'b00 : exp_q[0].wen);
        chk("run_last", last, exp_q[0].last);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] l, input logic [31:0] vs,
                       input logic m, input logic [VLMAX-1:0] v0);
    vl        = l;
    vstart    = vs;
    is_masked = m;
    v0_bits   = v0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int groups;
    RST = 1'b1; start = 1'b0; vl = '0; vstart = '0; is_masked = 1'b0;
    v0_bits = '0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_off0", woffset0, 0);
    chk("rst_off1", woffset1, 1);
    chk("rst_mask", {mask0, mask1}, 0);
    chk("rst_done", {done, vstart_clr, last}, 0);
    tick();

    // vl=5, vstart=0, unmasked.
    issue(32'd5, 32'd0, 1'b0, '1);
    chk("t1_g0_off", woffset0, 0);
    chk("t1_g0_wen", wen, 2'b11);
    chk("t1_g0_last", last, 0);
    tick();
    chk("t1_g1_off", woffset0, 2);
    chk("t1_g1_wen", wen, 2'b11);
    tick();
    chk("t1_g2_off", {woffset0, woffset1}, {8'd4, 8'd5});
    chk("t1_g2_wen", wen, 2'b01);
    chk("t1_g2_last", last, 1);
    tick();
    chk("t1_done", {done, vstart_clr, ready}, 3'b110);
    tick();
    chk("t1_ready", {ready, done}, 2'b10);

    // vl=6, vstart=3, masked, v0 bits 5 and 6 set (bit 6 is a tail element).
    issue(32'd6, 32'd3, 1'b1, 128'h60);
    chk("t2_g0_off", woffset0, 3);
    chk("t2_g0_mask", {mask0, mask1}, 2'b00);
    chk("t2_g0_wen", wen, 2'b00);
    tick();
    chk("t2_g1_off", woffset0, 5);
    chk("t2_g1_mask", {mask0, mask1}, 2'b10);
    chk("t2_g1_wen", wen, 2'b01);
    chk("t2_g1_last", last, 1);
    tick();
    chk("t2_done", done, 1);
    tick();

    // Empty instructions: vl=0, then vstart=vl=4.
    issue(32'd0, 32'd0, 1'b0, '1);
    chk("t3a_busy", busy, 0);
    chk("t3a_done", done, 1);
    tick();
    chk("t3a_ready", ready, 1);
    issue(32'd4, 32'd4, 1'b0, '1);
    chk("t3b_busy", busy, 0);
    chk("t3b_done", {done, vstart_clr}, 2'b11);
    tick();
    chk("t3b_ready", ready, 1);

    // vl=200 clamps to 128: 64 groups ending at (126,127).
    issue(32'd200, 32'd0, 1'b0, '1);
    groups = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      groups++;
      if (last) begin
        chk("t4_last_off", woffset0, 126);
        chk("t4_last_wen", wen, 2'b11);
      end
      tick();
    end
    chk("t4_groups", groups, 64);
    chk("t4_done", done, 1);
    tick();

    // Clamped vl with vstart=127: single group, lane 1 beyond the end.
    issue(32'd200, 32'd127, 1'b0, '1);
    chk("t4b_off", woffset0, 127);
    chk("t4b_wen", wen, 2'b01);
    chk("t4b_mask1", mask1, 0);
    chk("t4b_last", last, 1);
    tick();
    chk("t4b_done", done, 1);
    tick();

    // vl=8, stall three cycles on (2,3); a mid-run start is ignored.
    issue(32'd8, 32'd0, 1'b0, '0);
    tick();
    chk("t5_a_off", woffset0, 2);
    stall = 1'b1;
    tick();
    chk("t5_b_off", woffset0, 2);
    start = 1'b1; vl = 32'd2;
    tick();
    start = 1'b0;
    chk("t5_c_off", woffset0, 2);
    tick();
    stall = 1'b0;
    chk("t5_d_off", woffset0, 2);
    chk("t5_d_wen", wen, 2'b11);
    tick();
    chk("t5_e_off", woffset0, 4);
    tick();
    chk("t5_f_off", woffset0, 6);
    chk("t5_f_last", last, 1);
    tick();
    chk("t5_done", done, 1);
    tick();

    // Flush during (2,3) of vl=8.
    issue(32'd8, 32'd0, 1'b0, '1);
    tick();
    flush = 1'b1;
    #1;
    chk("t6_flush_wen", wen, 2'b00);
    tick();
    flush = 1'b0;
    chk("t6_idle", {ready, busy, done}, 3'b100);
    tick();
    chk("t6_nodone", done, 0);
    issue(32'd2, 32'd0, 1'b0, '1);
    chk("t6_new", {woffset0, 6'd0, wen, last}, {8'd0, 6'd0, 2'b11, 1'b1});
    tick();
    chk("t6_new_done", done, 1);
    tick();

    // Reset during (2,3) of vl=8.
    issue(32'd8, 32'd0, 1'b0, '1);
    tick();
    RST = 1'b1;
    #1;
    chk("t7_rst_wen", wen, 2'b00);
    tick();
    RST = 1'b0;
    chk("t7_idle", {ready, busy, done}, 3'b100);
    chk("t7_off", {woffset0, woffset1}, {8'd0, 8'd1});
    tick();
    chk("t7_nodone", done, 0);
    issue(32'd2, 32'd0, 1'b0, '1);
    chk("t7_new_wen", wen, 2'b11);
    chk("t7_new_last", last, 1);
    tick();
    chk("t7_new_done", done, 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
